// File: rtl/uart_cmd_ctrl.sv
// Command sequencer for the UART system: decodes RX command frames, drives the
// register file and ALU, and returns results byte by byte over the TX handshake.
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     REF_CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic                     RX_ERR,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic                     RF_WR_EN,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic                     RF_RD_EN,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_VLD,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     ALU_EN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_BUSY,
    output logic                     CMD_ERR
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_ADDR  = 4'd1;
    localparam logic [3:0] WR_DATA  = 4'd2;
    localparam logic [3:0] RD_ADDR  = 4'd3;
    localparam logic [3:0] RD_WAIT  = 4'd4;
    localparam logic [3:0] OPA      = 4'd5;
    localparam logic [3:0] OPB      = 4'd6;
    localparam logic [3:0] FUN      = 4'd7;
    localparam logic [3:0] ALU_WAIT = 4'd8;
    localparam logic [3:0] TX_LO    = 4'd9;
    localparam logic [3:0] TX_HI    = 4'd10;
    localparam logic [3:0] TX_WAIT  = 4'd11;

    localparam logic [DATA_WIDTH-1:0] OP_RF_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RF_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

    logic [3:0]               state;
    logic [ADDR_WIDTH-1:0]    addr_reg;
    logic [ALU_OUT_WIDTH-1:0] result;
    logic                     hi_pending;
    logic                     seen_busy;
    logic                     alu_go;
    logic                     collecting;

    always_comb begin
        collecting = (state == IDLE) || (state == WR_ADDR) || (state == WR_DATA) ||
                     (state == RD_ADDR) || (state == OPA) || (state == OPB) ||
                     (state == FUN);
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            addr_reg    <= '0;
            result      <= '0;
            hi_pending  <= 1'b0;
            seen_busy   <= 1'b0;
            alu_go      <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_EN    <= 1'b0;
            RF_WR_DATA  <= '0;
            RF_RD_EN    <= 1'b0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each one is a single-cycle pulse
            // unless a state explicitly re-asserts it.
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            TX_D_VLD <= 1'b0;
            CMD_ERR  <= 1'b0;
            ALU_EN   <= alu_go;
            alu_go   <= 1'b0;

            if (collecting && RX_D_VLD && RX_ERR) begin
                CMD_ERR <= 1'b1;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            OP_RF_WR:  state <= WR_ADDR;
                            OP_RF_RD:  state <= RD_ADDR;
                            OP_ALU_OP: state <= OPA;
                            OP_ALU_NO: state <= FUN;
                            default:   CMD_ERR <= 1'b1;
                        endcase
                    end
                    WR_ADDR: if (RX_D_VLD) begin
                        addr_reg <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state    <= WR_DATA;
                    end
                    WR_DATA: if (RX_D_VLD) begin
                        RF_ADDR    <= addr_reg;
                        RF_WR_DATA <= RX_P_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= IDLE;
                    end
                    RD_ADDR: if (RX_D_VLD) begin
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RF_RD_EN <= 1'b1;
                        state    <= RD_WAIT;
                    end
                    RD_WAIT: if (RF_RD_VLD) begin
                        result     <= ALU_OUT_WIDTH'(RF_RD_DATA);
                        hi_pending <= 1'b0;
                        state      <= TX_LO;
                    end
                    OPA: if (RX_D_VLD) begin
                        RF_ADDR    <= ADDR_WIDTH'(0);
                        RF_WR_DATA <= RX_P_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= OPB;
                    end
                    OPB: if (RX_D_VLD) begin
                        RF_ADDR    <= ADDR_WIDTH'(1);
                        RF_WR_DATA <= RX_P_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= FUN;
                    end
                    // Gate opens with the function code; the start pulse follows a cycle
                    // later so the gated ALU clock is running when ALU_EN arrives.
                    FUN: if (RX_D_VLD) begin
                        ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
                        CLK_GATE_EN <= 1'b1;
                        alu_go      <= 1'b1;
                        state       <= ALU_WAIT;
                    end
                    ALU_WAIT: if (ALU_OUT_VLD) begin
                        result      <= ALU_OUT;
                        hi_pending  <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state       <= TX_LO;
                    end
                    TX_LO: if (!TX_BUSY) begin
                        TX_P_DATA <= result[DATA_WIDTH-1:0];
                        TX_D_VLD  <= 1'b1;
                        seen_busy <= 1'b0;
                        state     <= TX_WAIT;
                    end
                    TX_HI: if (!TX_BUSY) begin
                        TX_P_DATA  <= result[ALU_OUT_WIDTH-1:DATA_WIDTH];
                        TX_D_VLD   <= 1'b1;
                        seen_busy  <= 1'b0;
                        hi_pending <= 1'b0;
                        state      <= TX_WAIT;
                    end
                    // A byte is done only after the transmitter has visibly taken it
                    // (busy high) and finished it (busy low again).
                    TX_WAIT: begin
                        if (TX_BUSY) begin
                            seen_busy <= 1'b1;
                        end else if (seen_busy) begin
                            state <= hi_pending ? TX_HI : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: behavioural register file, ALU and transmitter
// models respond to the DUT strobes while command frames are pushed in byte by byte.
module tb_uart_cmd_ctrl;

    logic        REF_CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RX_ERR;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic [7:0]  RF_WR_DATA;
    logic        RF_RD_EN;
    logic [7:0]  RF_RD_DATA  = 8'h00;
    logic        RF_RD_VLD   = 1'b0;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT     = 16'h0000;
    logic        ALU_OUT_VLD = 1'b0;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY     = 1'b0;
    logic        CMD_ERR;

    always #5 REF_CLK = ~REF_CLK;

    uart_cmd_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .ALU_OUT_WIDTH(16)
    ) dut (
        .REF_CLK(REF_CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
    );

    logic [29:0] out_bus;
    assign out_bus = {RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN,
                      CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model state, written only by the model process below.
    int          cyc = 0;
    logic [7:0]  rf_mem [16] = '{default: 8'h00};
    int          wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, tx_cnt = 0, tx_viol = 0;
    int          rd_dly = 0, alu_dly = 0, busy_dly = 0;
    logic [3:0]  last_wr_addr = '0, last_rd_addr = '0, fun_at_en = '0;
    logic [7:0]  last_wr_data = '0;
    logic        gate_at_en = 1'b0, gate_at_vld = 1'b0;
    logic [7:0]  tx_log [64];
    int          tx_cyc [64];

    // Stimulus-controlled knobs, written only by the initial block.
    logic        hold_busy = 1'b0;
    int          alu_lat = 4;
    logic [15:0] alu_result = 16'h0000;

    always @(posedge REF_CLK) cyc++;

    always @(negedge REF_CLK) begin
        RF_RD_VLD = 1'b0;
        if (rd_dly > 0) begin
            rd_dly--;
            if (rd_dly == 0) begin
                RF_RD_VLD  = 1'b1;
                RF_RD_DATA = rf_mem[last_rd_addr];
            end
        end
        if (RF_RD_EN) begin
            rd_cnt++;
            last_rd_addr = RF_ADDR;
            rd_dly = 2;
        end

        ALU_OUT_VLD = 1'b0;
        if (alu_dly > 0) begin
            alu_dly--;
            if (alu_dly == 0) begin
                ALU_OUT_VLD = 1'b1;
                ALU_OUT     = alu_result;
                gate_at_vld = CLK_GATE_EN;
            end
        end
        if (ALU_EN) begin
            alu_cnt++;
            fun_at_en  = ALU_FUN;
            gate_at_en = CLK_GATE_EN;
            alu_dly    = alu_lat;
        end

        if (RF_WR_EN) begin
            wr_cnt++;
            rf_mem[RF_ADDR] = RF_WR_DATA;
            last_wr_addr = RF_ADDR;
            last_wr_data = RF_WR_DATA;
        end
        if (CMD_ERR) err_cnt++;

        if (busy_dly > 0) busy_dly--;
        if (TX_D_VLD) begin
            if (TX_BUSY) tx_viol++;
            if (tx_cnt < 64) begin
                tx_log[tx_cnt] = TX_P_DATA;
                tx_cyc[tx_cnt] = cyc;
            end
            tx_cnt++;
            busy_dly = 8;
        end
        TX_BUSY = (busy_dly > 0) || hold_busy;
    end

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge REF_CLK);
        RX_P_DATA = b;
        RX_ERR    = err;
        RX_D_VLD  = 1'b1;
        @(negedge REF_CLK);
        RX_D_VLD  = 1'b0;
        RX_ERR    = 1'b0;
    endtask

    task automatic wait_tx(input int target, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (tx_cnt >= target) break;
            @(negedge REF_CLK);
        end
        check(tag, 32'(tx_cnt >= target), 32'd1);
    endtask

    int b_wr, b_rd, b_alu, b_err, b_tx, rel_cyc;

    initial begin
        RST = 1'b0;
        RX_P_DATA = '0;
        RX_D_VLD  = 1'b0;
        RX_ERR    = 1'b0;
        repeat (3) @(negedge REF_CLK);
        check("reset_outputs", 32'(out_bus), 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge REF_CLK);

        // RF write: AA 05 3C
        b_wr = wr_cnt; b_tx = tx_cnt;
        send_byte(8'hAA, 0); send_byte(8'h05, 0); send_byte(8'h3C, 0);
        repeat (4) @(negedge REF_CLK);
        check("wr_count", 32'(wr_cnt - b_wr), 32'd1);
        check("wr_addr", 32'(last_wr_addr), 32'h5);
        check("wr_data", 32'(last_wr_data), 32'h3C);
        check("wr_no_tx", 32'(tx_cnt - b_tx), 32'd0);

        // RF read: BB 05 -> one TX byte 3C
        b_rd = rd_cnt; b_tx = tx_cnt;
        send_byte(8'hBB, 0); send_byte(8'h05, 0);
        wait_tx(b_tx + 1, "rd_tx_timeout");
        repeat (12) @(negedge REF_CLK);
        check("rd_count", 32'(rd_cnt - b_rd), 32'd1);
        check("rd_addr", 32'(last_rd_addr), 32'h5);
        check("rd_tx_count", 32'(tx_cnt - b_tx), 32'd1);
        check("rd_tx_byte", 32'(tx_log[b_tx]), 32'h3C);

        // ALU with operands: CC 12 34 02, result 0408
        alu_result = 16'h0408;
        b_wr = wr_cnt; b_alu = alu_cnt; b_tx = tx_cnt;
        send_byte(8'hCC, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h02, 0);
        wait_tx(b_tx + 2, "alu_tx_timeout");
        repeat (12) @(negedge REF_CLK);
        check("alu_wr_count", 32'(wr_cnt - b_wr), 32'd2);
        check("alu_opa", 32'(rf_mem[0]), 32'h12);
        check("alu_opb", 32'(rf_mem[1]), 32'h34);
        check("alu_en_count", 32'(alu_cnt - b_alu), 32'd1);
        check("alu_fun", 32'(fun_at_en), 32'h2);
        check("gate_at_en", 32'(gate_at_en), 32'd1);
        check("gate_at_result", 32'(gate_at_vld), 32'd1);
        check("alu_tx_count", 32'(tx_cnt - b_tx), 32'd2);
        check("alu_tx_lo", 32'(tx_log[b_tx]), 32'h08);
        check("alu_tx_hi", 32'(tx_log[b_tx + 1]), 32'h04);
        check("gate_dropped", 32'(CLK_GATE_EN), 32'd0);

        // Errored data byte aborts the write
        b_wr = wr_cnt; b_err = err_cnt;
        send_byte(8'hAA, 0); send_byte(8'h07, 0); send_byte(8'h99, 1);
        repeat (3) @(negedge REF_CLK);
        check("abort_err", 32'(err_cnt - b_err), 32'd1);
        check("abort_no_wr", 32'(wr_cnt - b_wr), 32'd0);
        b_tx = tx_cnt;
        send_byte(8'hBB, 0); send_byte(8'h07, 0);
        wait_tx(b_tx + 1, "abort_rd_timeout");
        repeat (12) @(negedge REF_CLK);
        check("abort_rd_addr", 32'(last_rd_addr), 32'h7);
        check("abort_rd_byte", 32'(tx_log[b_tx]), 32'h00);
        check("abort_err_once", 32'(err_cnt - b_err), 32'd1);

        // Unknown opcode
        b_err = err_cnt; b_wr = wr_cnt; b_rd = rd_cnt; b_alu = alu_cnt; b_tx = tx_cnt;
        send_byte(8'h55, 0);
        repeat (3) @(negedge REF_CLK);
        check("bad_op_err", 32'(err_cnt - b_err), 32'd1);
        check("bad_op_quiet", 32'((wr_cnt - b_wr) + (rd_cnt - b_rd) + (alu_cnt - b_alu) + (tx_cnt - b_tx)), 32'd0);

        // ALU without operands, transmitter held busy
        alu_result = 16'hBEEF;
        hold_busy = 1'b1;
        b_alu = alu_cnt; b_tx = tx_cnt;
        send_byte(8'hDD, 0); send_byte(8'h01, 0);
        repeat (50) @(negedge REF_CLK);
        check("busy_holds_tx", 32'(tx_cnt - b_tx), 32'd0);
        hold_busy = 1'b0;
        rel_cyc = cyc;
        wait_tx(b_tx + 2, "busy_tx_timeout");
        repeat (12) @(negedge REF_CLK);
        check("busy_tx_after_release", 32'(tx_cyc[b_tx] > rel_cyc), 32'd1);
        check("busy_tx_lo", 32'(tx_log[b_tx]), 32'hEF);
        check("busy_tx_hi", 32'(tx_log[b_tx + 1]), 32'hBE);
        check("noop_fun", 32'(fun_at_en), 32'h1);
        check("noop_alu_count", 32'(alu_cnt - b_alu), 32'd1);
        check("noop_no_wr", 32'(wr_cnt - b_wr), 32'd0);

        // Reset while waiting on the ALU
        alu_lat = 30;
        b_tx = tx_cnt;
        send_byte(8'hDD, 0); send_byte(8'h03, 0);
        repeat (3) @(negedge REF_CLK);
        check("midrst_gate_on", 32'(CLK_GATE_EN), 32'd1);
        #2 RST = 1'b0;
        #1 check("midrst_outputs", 32'(out_bus), 32'd0);
        repeat (40) @(negedge REF_CLK);
        RST = 1'b1;
        alu_lat = 4;
        repeat (2) @(negedge REF_CLK);
        check("midrst_no_tx", 32'(tx_cnt - b_tx), 32'd0);
        send_byte(8'hBB, 0); send_byte(8'h00, 0);
        wait_tx(b_tx + 1, "midrst_rd_timeout");
        repeat (12) @(negedge REF_CLK);
        check("midrst_rd_byte", 32'(tx_log[b_tx]), 32'h12);

        check("tx_while_busy", 32'(tx_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
